// File: rtl/distortion_multimode.sv
// Three-stage waveshaping distortion: pre-gain with symmetric saturation, one of four
// clipping curves, and an output register with a saturating clip-event counter.
module distortion_multimode #(
   parameter  int WIDTH     = 24,
   parameter  int GAIN_W    = 8,
   parameter  int GAIN_FRAC = 4,
   parameter  int NUM_CH    = 2,
   parameter  int CNT_W     = 16,
   localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   input  logic [CH_W-1:0]     in_ch,
   input  logic [WIDTH-1:0]    in_sample,
   input  logic [1:0]          mode,
   input  logic [GAIN_W-1:0]   gain,
   input  logic [WIDTH-1:0]    threshold,
   input  logic                bypass,
   input  logic                clip_clr,
   output logic                out_valid,
   output logic [CH_W-1:0]     out_ch,
   output logic [WIDTH-1:0]    out_sample,
   output logic                clip_flag,
   output logic [CNT_W-1:0]    clip_count
);

   localparam int PW = WIDTH + GAIN_W + 1;
   localparam int MW = WIDTH + 1;

   // ---------------- S1: gain and saturation ----------------
   logic signed [PW-1:0] in_ext, gain_ext, prod, prod_sh, maxp;
   logic [WIDTH-1:0]     sat_x;
   logic                 sat_hit;

   assign in_ext   = {{(GAIN_W+1){in_sample[WIDTH-1]}}, in_sample};
   assign gain_ext = {{(WIDTH+1){1'b0}}, gain};
   assign maxp     = {{(GAIN_W+2){1'b0}}, {(WIDTH-1){1'b1}}};
   assign prod     = in_ext * gain_ext;
   assign prod_sh  = prod >>> GAIN_FRAC;

   always_comb begin
      sat_x   = prod_sh[WIDTH-1:0];
      sat_hit = 1'b0;
      if (prod_sh > maxp) begin
         sat_x   = {1'b0, {(WIDTH-1){1'b1}}};
         sat_hit = 1'b1;
      end else if (prod_sh < -maxp) begin
         sat_x   = {1'b1, {(WIDTH-2){1'b0}}, 1'b1};
         sat_hit = 1'b1;
      end
   end

   logic              s1_valid, s1_sat, s1_byp;
   logic [CH_W-1:0]   s1_ch;
   logic [WIDTH-1:0]  s1_raw, s1_x, s1_thr;
   logic [1:0]        s1_mode;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_sat   <= 1'b0;
         s1_byp   <= 1'b0;
         s1_ch    <= '0;
         s1_raw   <= '0;
         s1_x     <= '0;
         s1_thr   <= '0;
         s1_mode  <= '0;
      end else begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_sat  <= sat_hit;
            s1_byp  <= bypass;
            s1_ch   <= in_ch;
            s1_raw  <= in_sample;
            s1_x    <= sat_x;
            s1_thr  <= threshold;
            s1_mode <= mode;
         end
      end
   end

   // ---------------- S2: shaping on magnitudes ----------------
   // x is symmetric after saturation, so |x| always fits and the sign can be reapplied.
   logic             s_neg, shape_hit;
   logic [MW-1:0]    a, tp, k, tp2, soft_m, lim, mag;
   logic [WIDTH-1:0] neg_x, y;

   assign s_neg = s1_x[WIDTH-1];
   assign neg_x = -s1_x;

   always_comb begin
      a      = {1'b0, (s_neg ? neg_x : s1_x)};
      tp     = s1_thr[WIDTH-1] ? '0 : {1'b0, s1_thr};
      k      = tp >> 1;
      tp2    = tp << 1;
      soft_m = k + ((a - k) >> 1);
      lim    = s_neg ? k : tp;
      mag    = a;
      case (s1_mode)
         2'b00: mag = (a < tp) ? a : tp;
         2'b01: if (a > k) mag = (soft_m < tp) ? soft_m : tp;
         2'b10: mag = (a < lim) ? a : lim;
         default: if (a > tp) mag = (tp2 > a) ? (tp2 - a) : '0;
      endcase
      y         = s_neg ? -mag[WIDTH-1:0] : mag[WIDTH-1:0];
      shape_hit = (mag != a);
   end

   logic              s2_valid, s2_flag;
   logic [CH_W-1:0]   s2_ch;
   logic [WIDTH-1:0]  s2_y;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2_flag  <= 1'b0;
         s2_ch    <= '0;
         s2_y     <= '0;
      end else begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_flag <= s1_byp ? 1'b0 : (s1_sat | shape_hit);
            s2_ch   <= s1_ch;
            s2_y    <= s1_byp ? s1_raw : y;
         end
      end
   end

   // ---------------- S3: output register and clip counter ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_ch     <= '0;
         out_sample <= '0;
         clip_flag  <= 1'b0;
      end else begin
         out_valid <= s2_valid;
         if (s2_valid) begin
            out_ch     <= s2_ch;
            out_sample <= s2_y;
            clip_flag  <= s2_flag;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clip_count <= '0;
      end else if (clip_clr) begin
         clip_count <= '0;
      end else if (s2_valid && s2_flag && (clip_count != {CNT_W{1'b1}})) begin
         clip_count <= clip_count + 1'b1;
      end
   end

endmodule
